// File: rtl/nasti_stream_reader.sv
// Read mover: fetches r_len 64-bit words from NASTI memory in INCR bursts and replays them on a
// stream master. Optional sticky read-error flag under NASTI_STREAM_READER_ERR_EN.
module nasti_stream_reader #(
    parameter int unsigned ADDR_WIDTH       = 64,
    parameter int unsigned DATA_WIDTH       = 64,
    parameter int unsigned MAX_BURST_LENGTH = 8,
    parameter int unsigned LEN_WIDTH        = 16
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    // memory read side
    output logic                      src_ar_valid_o,
    input  logic                      src_ar_ready_i,
    output logic [ADDR_WIDTH-1:0]     src_ar_addr_o,
    output logic [7:0]                src_ar_len_o,
    output logic [2:0]                src_ar_size_o,
    output logic [1:0]                src_ar_burst_o,
    output logic                      src_ar_id_o,
    output logic [3:0]                src_ar_cache_o,
    output logic [2:0]                src_ar_prot_o,
    output logic                      src_ar_lock_o,
    input  logic                      src_r_valid_i,
    output logic                      src_r_ready_o,
    input  logic [DATA_WIDTH-1:0]     src_r_data_i,
    input  logic                      src_r_last_i,
    input  logic [1:0]                src_r_resp_i,
    output logic                      src_aw_valid_o,
    output logic                      src_w_valid_o,
    output logic                      src_b_ready_o,
    // stream side
    output logic                      dest_t_valid_o,
    input  logic                      dest_t_ready_i,
    output logic [DATA_WIDTH-1:0]     dest_t_data_o,
    output logic [DATA_WIDTH/8-1:0]   dest_t_keep_o,
    output logic [DATA_WIDTH/8-1:0]   dest_t_strb_o,
    output logic                      dest_t_last_o,
    // request
    input  logic [ADDR_WIDTH-1:0]     r_src_i,
    input  logic [LEN_WIDTH-1:0]      r_len_i,
    input  logic                      r_valid_i,
    output logic                      r_ready_o
`ifdef NASTI_STREAM_READER_ERR_EN
    ,
    output logic                      err_o
`endif
);

    localparam int unsigned BytesPerBeat = DATA_WIDTH / 8;
    localparam int unsigned AlignBits    = $clog2(BytesPerBeat);
    localparam int unsigned PtrW         = $clog2(MAX_BURST_LENGTH);
    localparam int unsigned CntW         = PtrW + 1;

    typedef enum logic [2:0] {StIdle, StNull, StAddr, StRead, StStream} state_e;

    state_e                  state_q, state_d;
    logic                    req_ready_q, req_ready_d;
    logic                    ar_valid_q, ar_valid_d;
    logic [ADDR_WIDTH-1:0]   ar_addr_q, ar_addr_d;
    logic [7:0]              ar_len_q, ar_len_d;
    logic                    rd_en_q, rd_en_d;
    logic                    t_valid_q, t_valid_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LEN_WIDTH-1:0]    remain_q, remain_d;
    logic [CntW-1:0]         burst_n_q, burst_n_d;
    logic [CntW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0]   mem_q [MAX_BURST_LENGTH];

    logic                    req_fire, ar_fire, r_fire, t_fire;
    logic [CntW-1:0]         next_n;
    logic                    last_entry;
    logic                    final_burst;

    assign req_fire    = r_valid_i && req_ready_q;
    assign ar_fire     = ar_valid_q && src_ar_ready_i;
    assign r_fire      = src_r_valid_i && rd_en_q;
    assign t_fire      = t_valid_q && dest_t_ready_i;
    assign last_entry  = ({1'b0, rd_ptr_q} == burst_n_q - CntW'(1));
    assign final_burst = (remain_q == LEN_WIDTH'(burst_n_q));

    always_comb begin
        next_n = CntW'(MAX_BURST_LENGTH);
        if (remain_q < LEN_WIDTH'(MAX_BURST_LENGTH)) begin
            next_n = remain_q[CntW-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        ar_valid_d  = ar_valid_q;
        ar_addr_d   = ar_addr_q;
        ar_len_d    = ar_len_q;
        rd_en_d     = rd_en_q;
        t_valid_d   = t_valid_q;
        addr_d      = addr_q;
        remain_d    = remain_q;
        burst_n_d   = burst_n_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (req_fire) begin
                    addr_d      = r_src_i & ~ADDR_WIDTH'(BytesPerBeat - 1);
                    remain_d    = r_len_i;
                    req_ready_d = 1'b0;
                end else if (!req_ready_q) begin
                    // a request (or the remainder of one) is pending
                    if (remain_q == '0) begin
                        t_valid_d = 1'b1;
                        state_d   = StNull;
                    end else begin
                        burst_n_d  = next_n;
                        ar_valid_d = 1'b1;
                        ar_addr_d  = addr_q;
                        ar_len_d   = 8'(next_n - CntW'(1));
                        state_d    = StAddr;
                    end
                end
            end
            StNull: begin
                if (t_fire) begin
                    t_valid_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StAddr: begin
                if (ar_fire) begin
                    ar_valid_d = 1'b0;
                    rd_en_d    = 1'b1;
                    wr_ptr_d   = '0;
                    state_d    = StRead;
                end
            end
            StRead: begin
                if (r_fire) begin
                    wr_ptr_d = wr_ptr_q + CntW'(1);
                    if (src_r_last_i) begin
                        // stream what actually arrived, even on a short burst
                        burst_n_d = wr_ptr_q + CntW'(1);
                        rd_en_d   = 1'b0;
                        rd_ptr_d  = '0;
                        t_valid_d = 1'b1;
                        state_d   = StStream;
                    end
                end
            end
            StStream: begin
                if (t_fire) begin
                    if (last_entry) begin
                        addr_d    = addr_q + (ADDR_WIDTH'(burst_n_q) << AlignBits);
                        remain_d  = remain_q - LEN_WIDTH'(burst_n_q);
                        t_valid_d = 1'b0;
                        state_d   = StIdle;
                        if (final_burst) begin
                            req_ready_d = 1'b1;
                        end
                    end else begin
                        rd_ptr_d = rd_ptr_q + PtrW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= StIdle;
            req_ready_q <= 1'b1;
            ar_valid_q  <= 1'b0;
            ar_addr_q   <= '0;
            ar_len_q    <= '0;
            rd_en_q     <= 1'b0;
            t_valid_q   <= 1'b0;
            addr_q      <= '0;
            remain_q    <= '0;
            burst_n_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            ar_valid_q  <= ar_valid_d;
            ar_addr_q   <= ar_addr_d;
            ar_len_q    <= ar_len_d;
            rd_en_q     <= rd_en_d;
            t_valid_q   <= t_valid_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            burst_n_q   <= burst_n_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (state_q == StRead && r_fire) begin
            mem_q[wr_ptr_q[PtrW-1:0]] <= src_r_data_i;
        end
    end

    always_ff @(posedge aclk) begin
        if (aresetn) begin
            if (req_fire) begin
                assert ((r_src_i & ADDR_WIDTH'(BytesPerBeat - 1)) == '0)
                else $error("nasti_stream_reader: misaligned r_src %0h", r_src_i);
            end
            if (state_q == StRead && r_fire && src_r_last_i) begin
                assert (wr_ptr_q + CntW'(1) == burst_n_q)
                else $error("nasti_stream_reader: r_last after %0d beats, expected %0d",
                            wr_ptr_q + CntW'(1), burst_n_q);
            end
        end
    end

`ifdef NASTI_STREAM_READER_ERR_EN
    logic err_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_q <= 1'b0;
        end else if (req_fire) begin
            err_q <= 1'b0;
        end else if (r_fire && src_r_resp_i[1]) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    logic unused_resp;
    assign unused_resp = ^src_r_resp_i;
`endif

    assign r_ready_o      = req_ready_q;
    assign src_ar_valid_o = ar_valid_q;
    assign src_ar_addr_o  = ar_addr_q;
    assign src_ar_len_o   = ar_len_q;
    assign src_ar_size_o  = 3'(AlignBits);
    assign src_ar_burst_o = 2'b01;
    assign src_ar_id_o    = 1'b0;
    assign src_ar_cache_o = 4'b0000;
    assign src_ar_prot_o  = 3'b000;
    assign src_ar_lock_o  = 1'b0;
    assign src_r_ready_o  = rd_en_q;
    assign src_aw_valid_o = 1'b0;
    assign src_w_valid_o  = 1'b0;
    assign src_b_ready_o  = 1'b0;

    assign dest_t_valid_o = t_valid_q;
    assign dest_t_data_o  = (state_q == StStream) ? mem_q[rd_ptr_q] : '0;
    assign dest_t_keep_o  = (state_q == StNull) ? '0 : '1;
    assign dest_t_strb_o  = (state_q == StNull) ? '0 : '1;
    assign dest_t_last_o  = (state_q == StNull) ||
                            (state_q == StStream && last_entry && final_burst);

endmodule

// File: tb/tb_nasti_stream_reader.sv
// Randomised bench for nasti_stream_reader: memory slave + stream sink agents, checked against a
// request-level model of the expected AR bursts and stream beats.
module tb_nasti_stream_reader;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        src_ar_valid_o, src_ar_ready_i;
    logic [63:0] src_ar_addr_o;
    logic [7:0]  src_ar_len_o;
    logic [2:0]  src_ar_size_o;
    logic [1:0]  src_ar_burst_o;
    logic        src_ar_id_o;
    logic [3:0]  src_ar_cache_o;
    logic [2:0]  src_ar_prot_o;
    logic        src_ar_lock_o;
    logic        src_r_valid_i, src_r_ready_o;
    logic [63:0] src_r_data_i;
    logic        src_r_last_i;
    logic [1:0]  src_r_resp_i;
    logic        src_aw_valid_o, src_w_valid_o, src_b_ready_o;
    logic        dest_t_valid_o, dest_t_ready_i;
    logic [63:0] dest_t_data_o;
    logic [7:0]  dest_t_keep_o, dest_t_strb_o;
    logic        dest_t_last_o;
    logic [63:0] r_src_i;
    logic [15:0] r_len_i;
    logic        r_valid_i, r_ready_o;
`ifdef NASTI_STREAM_READER_ERR_EN
    logic        err_o;
`endif

    nasti_stream_reader dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .src_ar_valid_o (src_ar_valid_o),
        .src_ar_ready_i (src_ar_ready_i),
        .src_ar_addr_o  (src_ar_addr_o),
        .src_ar_len_o   (src_ar_len_o),
        .src_ar_size_o  (src_ar_size_o),
        .src_ar_burst_o (src_ar_burst_o),
        .src_ar_id_o    (src_ar_id_o),
        .src_ar_cache_o (src_ar_cache_o),
        .src_ar_prot_o  (src_ar_prot_o),
        .src_ar_lock_o  (src_ar_lock_o),
        .src_r_valid_i  (src_r_valid_i),
        .src_r_ready_o  (src_r_ready_o),
        .src_r_data_i   (src_r_data_i),
        .src_r_last_i   (src_r_last_i),
        .src_r_resp_i   (src_r_resp_i),
        .src_aw_valid_o (src_aw_valid_o),
        .src_w_valid_o  (src_w_valid_o),
        .src_b_ready_o  (src_b_ready_o),
        .dest_t_valid_o (dest_t_valid_o),
        .dest_t_ready_i (dest_t_ready_i),
        .dest_t_data_o  (dest_t_data_o),
        .dest_t_keep_o  (dest_t_keep_o),
        .dest_t_strb_o  (dest_t_strb_o),
        .dest_t_last_o  (dest_t_last_o),
        .r_src_i        (r_src_i),
        .r_len_i        (r_len_i),
        .r_valid_i      (r_valid_i),
        .r_ready_o      (r_ready_o)
`ifdef NASTI_STREAM_READER_ERR_EN
        ,
        .err_o          (err_o)
`endif
    );

    always #5 aclk = ~aclk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // memory word at byte address a; word 0x1000 reads 0x100
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        return (a >> 3) - 64'h100;
    endfunction

    // ---------------- memory slave ----------------
    int          rmode   = 0;
    int          gbeat   = 0;
    int          err_beat = -1;
    int          beat_i  = 0;
    logic [63:0] pend_addr[$];
    logic [7:0]  pend_len[$];
    logic [63:0] ar_log_addr[$];
    logic [7:0]  ar_log_len[$];

    always begin
        logic ar_take, r_take;
        @(negedge aclk);
        ar_take = src_ar_valid_o && src_ar_ready_i;
        r_take  = src_r_valid_i && src_r_ready_o;
        if (ar_take) begin
            pend_addr.push_back(src_ar_addr_o);
            pend_len.push_back(src_ar_len_o);
            ar_log_addr.push_back(src_ar_addr_o);
            ar_log_len.push_back(src_ar_len_o);
            check_eq("ar_attrs", {src_ar_size_o, src_ar_burst_o, src_ar_id_o, src_ar_cache_o,
                                  src_ar_prot_o, src_ar_lock_o},
                     {3'b011, 2'b01, 1'b0, 4'b0000, 3'b000, 1'b0});
        end
        @(posedge aclk);
        #1;
        if (!aresetn) begin
            pend_addr.delete();
            pend_len.delete();
            beat_i         = 0;
            src_r_valid_i  = 1'b0;
            src_ar_ready_i = 1'b0;
        end else begin
            if (r_take) begin
                gbeat++;
                if (beat_i == int'(pend_len[0])) begin
                    void'(pend_addr.pop_front());
                    void'(pend_len.pop_front());
                    beat_i = 0;
                end else begin
                    beat_i++;
                end
            end
            if (pend_len.size() == 0) begin
                src_r_valid_i = 1'b0;
            end else if (!src_r_valid_i || r_take) begin
                src_r_valid_i = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
                src_r_data_i  = mem_word(pend_addr[0] + 64'(8 * beat_i));
                src_r_last_i  = (beat_i == int'(pend_len[0]));
                src_r_resp_i  = (gbeat == err_beat) ? 2'b10 : 2'b00;
            end
            src_ar_ready_i = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- stream sink ----------------
    int          tmode = 0;
    logic [63:0] cap_data[$];
    logic [7:0]  cap_keep[$];
    logic        cap_last[$];

    always begin
        logic        stalled = 1'b0;
        logic [63:0] hold_data;
        logic        hold_last;
        @(negedge aclk);
        if (!aresetn) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check_eq("hold_valid", 64'(dest_t_valid_o), 64'd1);
                check_eq("hold_data", dest_t_data_o, hold_data);
                check_eq("hold_last", 64'(dest_t_last_o), 64'(hold_last));
            end
            if (dest_t_valid_o && dest_t_ready_i) begin
                cap_data.push_back(dest_t_data_o);
                cap_keep.push_back(dest_t_keep_o);
                cap_last.push_back(dest_t_last_o);
                check_eq("keep_eq_strb", 64'(dest_t_strb_o), 64'(dest_t_keep_o));
            end
            stalled   = dest_t_valid_o && !dest_t_ready_i;
            hold_data = dest_t_data_o;
            hold_last = dest_t_last_o;
        end
        @(posedge aclk);
        #1;
        case (tmode)
            0:       dest_t_ready_i = 1'b1;
            1:       dest_t_ready_i = ~dest_t_ready_i;
            default: dest_t_ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    // ---------------- sequencing ----------------
    task automatic check_reset_outputs();
        check_eq("rst_r_ready", 64'(r_ready_o), 64'd1);
        check_eq("rst_ar_valid", 64'(src_ar_valid_o), 64'd0);
        check_eq("rst_src_r_ready", 64'(src_r_ready_o), 64'd0);
        check_eq("rst_t_valid", 64'(dest_t_valid_o), 64'd0);
        check_eq("tieoff_write", {61'd0, src_aw_valid_o, src_w_valid_o, src_b_ready_o}, 64'd0);
`ifdef NASTI_STREAM_READER_ERR_EN
        check_eq("rst_err", 64'(err_o), 64'd0);
`endif
    endtask

    task automatic clear_logs();
        cap_data.delete();
        cap_keep.delete();
        cap_last.delete();
        ar_log_addr.delete();
        ar_log_len.delete();
        gbeat = 0;
    endtask

    task automatic send_req(input logic [63:0] src, input int len, input bit vstall);
        bit acc = 1'b0;
        if (vstall) repeat ($urandom_range(0, 4)) @(posedge aclk);
        @(posedge aclk);
        #1;
        r_src_i   = src;
        r_len_i   = 16'(len);
        r_valid_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (r_ready_o) begin
                acc = 1'b1;
                break;
            end
        end
        @(posedge aclk);
        #1;
        r_valid_i = 1'b0;
        check_eq("req_accepted", 64'(acc), 64'd1);
    endtask

    task automatic wait_done(input int exp_beats);
        bit done = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge aclk);
            if (cap_data.size() >= exp_beats && r_ready_o) begin
                done = 1'b1;
                break;
            end
        end
        check_eq("done_in_time", 64'(done), 64'd1);
        repeat (4) @(negedge aclk);
    endtask

    task automatic verify(input logic [63:0] src, input int len);
        int eb = (len == 0) ? 1 : len;
        int k  = 0;
        check_eq("beat_count", 64'(cap_data.size()), 64'(eb));
        for (int i = 0; i < eb && i < cap_data.size(); i++) begin
            if (len == 0) begin
                check_eq("null_data", cap_data[i], 64'd0);
                check_eq("null_keep", 64'(cap_keep[i]), 64'd0);
                check_eq("null_last", 64'(cap_last[i]), 64'd1);
            end else begin
                check_eq("beat_data", cap_data[i], mem_word(src + 64'(8 * i)));
                check_eq("beat_keep", 64'(cap_keep[i]), 64'hff);
                check_eq("beat_last", 64'(cap_last[i]), 64'(i == len - 1));
            end
        end
        for (int off = 0; off < len; off += 8) k++;
        check_eq("ar_count", 64'(ar_log_addr.size()), 64'(k));
        k = 0;
        for (int off = 0; off < len; off += 8) begin
            int n = (len - off < 8) ? len - off : 8;
            if (k < ar_log_addr.size()) begin
                check_eq("ar_addr", ar_log_addr[k], src + 64'(8 * off));
                check_eq("ar_len", 64'(ar_log_len[k]), 64'(n - 1));
            end
            k++;
        end
        check_eq("ready_after", 64'(r_ready_o), 64'd1);
    endtask

    task automatic run_req(input logic [63:0] src, input int len, input int tm, input int rm,
                           input bit vstall);
        tmode = tm;
        rmode = rm;
        clear_logs();
        send_req(src, len, vstall);
        wait_done((len == 0) ? 1 : len);
        verify(src, len);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lasts;
        aresetn        = 1'b0;
        r_valid_i      = 1'b0;
        r_src_i        = '0;
        r_len_i        = '0;
        src_ar_ready_i = 1'b0;
        src_r_valid_i  = 1'b0;
        src_r_data_i   = '0;
        src_r_last_i   = 1'b0;
        src_r_resp_i   = 2'b00;
        dest_t_ready_i = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_reset_outputs();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        run_req(64'h1000, 8, 0, 0, 1'b0);
        run_req(64'h2000, 19, 0, 0, 1'b0);
        run_req(64'h3000, 0, 0, 0, 1'b0);
        run_req(64'h1000, 8, 1, 1, 1'b1);

        // reset in the middle of the second burst's stream phase
        tmode = 2;
        rmode = 1;
        clear_logs();
        send_req(64'h4000, 16, 1'b0);
        for (int i = 0; i < 4000 && cap_data.size() < 10; i++) @(negedge aclk);
        check_eq("reached_stream", 64'(cap_data.size() >= 10), 64'd1);
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(negedge aclk);
        check_reset_outputs();
        repeat (2) @(negedge aclk);
        check_reset_outputs();
        lasts = 0;
        foreach (cap_last[i]) lasts += int'(cap_last[i]);
        check_eq("no_last_before_reset", 64'(lasts), 64'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        run_req(64'h5000, 2, 0, 0, 1'b0);

`ifdef NASTI_STREAM_READER_ERR_EN
        tmode = 0;
        rmode = 0;
        clear_logs();
        err_beat = 2;
        send_req(64'h6000, 8, 1'b0);
        wait_done(8);
        verify(64'h6000, 8);
        check_eq("err_set", 64'(err_o), 64'd1);
        err_beat = -1;
        clear_logs();
        send_req(64'h7000, 3, 1'b0);
        check_eq("err_cleared", 64'(err_o), 64'd0);
        wait_done(3);
        verify(64'h7000, 3);
        check_eq("err_stays_clear", 64'(err_o), 64'd0);
`endif

        for (int t = 0; t < 10; t++) begin
            logic [63:0] src = 64'($urandom_range(1, 255)) << 12;
            run_req(src, $urandom_range(0, 40), $urandom_range(0, 2), $urandom_range(0, 1),
                    1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
